uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- Receive-side neighbour of the debug UART transmitter; consumes the serial `rx` pin.
- Recovers 8N1 bytes by mid-bit sampling.
- Locks onto the 0xFF sync preamble and reassembles 4-byte frames in the order custom_cmd, cmd, data[15:8], data[7:0].
- Presents each complete frame as parallel fields with a one-cycle valid strobe, for project logic or loopback checking.

Parameters:
- CLKS_PER_BIT, 5000: clock cycles per UART bit; must match the transmitter (48 MHz / 9600).
- SYNC_BYTES, 2: consecutive 0xFF bytes required to achieve lock.
- TIMEOUT_BITS, 20: inter-byte idle limit in bit times; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rx  in  1  serial input, idle high, asynchronous to clk
- o_rx_dv  out  1  one-cycle strobe: o_rx_byte valid
- o_rx_byte  out  8  last correctly framed byte
- o_frame_err  out  1  one-cycle strobe: stop bit sampled low
- o_locked  out  1  sync preamble seen, assembler collecting frames
- o_frame_valid  out  1  one-cycle strobe: frame fields updated
- o_custom_cmd  out  8  frame byte 0
- o_cmd  out  8  frame byte 1
- o_data  out  16  frame bytes 2 (MSB) and 3 (LSB)

Behaviour:
- Reset (one clock; reset is asynchronous and active-low):
  - Asserting reset_n low immediately clears every state register, including mid-byte or mid-frame.
  - All outputs reset to 0; synchroniser flops reset to 1.
  - After release, reception starts clean in IDLE/HUNT.
- Input sync: rx passes through a 2-flop synchroniser; all logic uses the synchronised value rxs.
- Byte FSM, states IDLE, START, DATA, STOP, CLEANUP:
  - IDLE: counters at 0. Go to START when rxs==0.
  - START: count to (CLKS_PER_BIT-1)/2 (integer division). If rxs is still 0, clear the counter and go to DATA; otherwise treat as a glitch and return to IDLE with no strobe.
  - DATA: count to CLKS_PER_BIT-1, then sample rxs into bit[idx], LSB first. idx runs 0..7; after bit 7 go to STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample rxs.
    - Sample 1: load o_rx_byte and pulse o_rx_dv for exactly one cycle.
    - Sample 0: pulse o_frame_err for one cycle; no o_rx_dv; o_rx_byte unchanged.
    - Either way go to CLEANUP.
  - CLEANUP: one cycle, then IDLE. A start bit is accepted on the next cycle.
- Counter width: 32 bits, matching the transmitter; never wraps at legal CLKS_PER_BIT.
- Frame assembler, states HUNT and COLLECT; advances only on o_rx_dv or o_frame_err.
  - HUNT:
    - 0xFF increments sync_cnt.
    - Any other byte clears sync_cnt.
    - When sync_cnt reaches SYNC_BYTES: set o_locked=1, idx=0, go to COLLECT.
  - COLLECT:
    - idx==0 and byte==0xFF: sync filler; discard and stay at idx 0. A custom_cmd of 0xFF cannot be carried.
    - Otherwise store the byte into the shadow register selected by idx and increment idx.
    - When byte idx 3 arrives: in the next cycle, copy all shadows to the outputs, pulse o_frame_valid for one cycle, and set idx=0. Latency is one cycle after the final o_rx_dv.
  - Any o_frame_err, in either state: go to HUNT, o_locked=0, sync_cnt=0, idx=0. A partial frame is discarded and the outputs hold their previous frame.
- Output fields change only together with o_frame_valid and are held between frames.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- Defined:
  - A 32-bit idle counter runs while in COLLECT with idx!=0.
  - It clears on every o_rx_dv.
  - On reaching TIMEOUT_BITS*CLKS_PER_BIT: discard the partial frame, set idx=0, keep o_locked=1, and raise no strobe.
- Undefined: the counter and its logic are absent; a partial frame waits indefinitely for its remaining bytes.

Test Plan (bench uses CLKS_PER_BIT=16):
- Reset mid-byte: drive reset_n low in the middle of DATA, release, then send 0x55 → o_rx_byte=0x55 with one o_rx_dv pulse. All outputs read 0 during reset.
- Glitch rejection: rx low for 4 clocks then high → no o_rx_dv, FSM back in IDLE; a following 0xA3 byte is received correctly.
- Lock and frame: send FF FF 12 34 AB CD → o_locked=1 after the second FF; o_frame_valid pulses once, 1 cycle after the last o_rx_dv; o_custom_cmd=0x12, o_cmd=0x34, o_data=0xABCD.
- Filler and back-to-back frames: send 13×FF, then 01 02 03 04, then 05 06 07 08 → two o_frame_valid pulses with o_data=0x0304 then 0x0708; no frame is built from the FF fillers.
- Framing error: after lock, send 01 02, then a byte with stop bit 0 → one o_frame_err pulse, o_locked=0, outputs unchanged. Then FF FF 09 0A 0B 0C → relock and o_data=0x0B0C.
- With UART_RX_TIMEOUT_EN and TIMEOUT_BITS=20: after lock, send 01 02, idle 400 clocks, send 11 22 33 44 → o_custom_cmd=0x11, o_cmd=0x22, o_data=0x3344.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver with sync-preamble lock and 4-byte frame
// reassembly (custom_cmd, cmd, data[15:8], data[7:0]).
//
// Optional build macro: UART_RX_TIMEOUT_EN -- adds an inter-byte idle timeout
// that drops a partial frame while staying locked.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   rx            serial input, idle high, asynchronous to clk
//   o_rx_dv       one-cycle strobe, o_rx_byte valid
//   o_rx_byte     last correctly framed byte
//   o_frame_err   one-cycle strobe, stop bit sampled low
//   o_locked      preamble seen, assembler collecting frames
//   o_frame_valid one-cycle strobe, frame fields updated
//   o_custom_cmd  frame byte 0
//   o_cmd         frame byte 1
//   o_data        frame bytes 2 (MSB) and 3 (LSB)
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 5000,
  parameter int SYNC_BYTES   = 2,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  output logic        o_rx_dv,
  output logic [7:0]  o_rx_byte,
  output logic        o_frame_err,
  output logic        o_locked,
  output logic        o_frame_valid,
  output logic [7:0]  o_custom_cmd,
  output logic [7:0]  o_cmd,
  output logic [15:0] o_data
);

  localparam logic [31:0] BIT_LAST = 32'(CLKS_PER_BIT - 1);
  localparam logic [31:0] HALF_BIT = 32'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0]  SYNC_TGT = 8'(SYNC_BYTES);
  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_BITS * CLKS_PER_BIT);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP} rx_state_e;
  typedef enum logic {A_HUNT, A_COLLECT} asm_state_e;

  // Two-flop synchroniser; resets to the idle (high) line level.
  logic rx_meta_q, rxs_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // Byte receiver
  rx_state_e   rx_state_q, rx_state_d;
  logic [31:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_dv_q, rx_dv_d;
  logic        frame_err_q, frame_err_d;

  always_comb begin
    rx_state_d  = rx_state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_dv_d     = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rxs_q) rx_state_d = S_START;
      end
      S_START: begin
        if (clk_cnt_q == HALF_BIT) begin
          clk_cnt_d  = '0;
          // Line back high at mid start bit: a glitch, not a start.
          rx_state_d = rxs_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rxs_q;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d  = '0;
            rx_state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rxs_q) begin
            rx_byte_d = shift_q;
            rx_dv_d   = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          rx_state_d = S_CLEANUP;
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end
      S_CLEANUP: rx_state_d = S_IDLE;
      default:   rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q  <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_dv_q     <= rx_dv_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Frame assembler
  asm_state_e  asm_q, asm_d;
  logic [7:0]  sync_cnt_q, sync_cnt_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [7:0]  sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic        locked_q, locked_d;
  logic        fv_q, fv_d;
  logic [7:0]  custom_q, custom_d, cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic [31:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    asm_d      = asm_q;
    sync_cnt_d = sync_cnt_q;
    col_idx_d  = col_idx_q;
    sh0_d      = sh0_q;
    sh1_d      = sh1_q;
    sh2_d      = sh2_q;
    locked_d   = locked_q;
    fv_d       = 1'b0;
    custom_d   = custom_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    idle_cnt_d = '0;
    if (frame_err_q) begin
      asm_d      = A_HUNT;
      locked_d   = 1'b0;
      sync_cnt_d = '0;
      col_idx_d  = '0;
    end else if (rx_dv_q) begin
      if (asm_q == A_HUNT) begin
        if (rx_byte_q == 8'hFF) begin
          if (sync_cnt_q + 8'd1 >= SYNC_TGT) begin
            asm_d      = A_COLLECT;
            locked_d   = 1'b1;
            sync_cnt_d = '0;
            col_idx_d  = '0;
          end else begin
            sync_cnt_d = sync_cnt_q + 8'd1;
          end
        end else begin
          sync_cnt_d = '0;
        end
      end else if (!(col_idx_q == 2'd0 && rx_byte_q == 8'hFF)) begin
        // 0xFF at byte 0 is preamble filler and is dropped.
        case (col_idx_q)
          2'd0: sh0_d = rx_byte_q;
          2'd1: sh1_d = rx_byte_q;
          2'd2: sh2_d = rx_byte_q;
          default: begin
            // Last byte goes straight to the outputs so the frame
            // appears one cycle after its final byte strobe.
            custom_d = sh0_q;
            cmd_d    = sh1_q;
            data_d   = {sh2_q, rx_byte_q};
            fv_d     = 1'b1;
          end
        endcase
        col_idx_d = col_idx_q + 2'd1;  // 3 wraps to 0
      end
    end
`ifdef UART_RX_TIMEOUT_EN
    else if (asm_q == A_COLLECT && col_idx_q != 2'd0) begin
      if (idle_cnt_q == TO_LIMIT) begin
        col_idx_d = '0;  // drop partial frame, remain locked
      end else begin
        idle_cnt_d = idle_cnt_q + 32'd1;
      end
    end
`endif
  end

`ifndef UART_RX_TIMEOUT_EN
  // TIMEOUT_BITS only matters when the idle timeout is built in.
  logic unused_timeout;
  assign unused_timeout = ^{TO_LIMIT, idle_cnt_q};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_q      <= A_HUNT;
      sync_cnt_q <= '0;
      col_idx_q  <= '0;
      sh0_q      <= '0;
      sh1_q      <= '0;
      sh2_q      <= '0;
      locked_q   <= 1'b0;
      fv_q       <= 1'b0;
      custom_q   <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      idle_cnt_q <= '0;
    end else begin
      asm_q      <= asm_d;
      sync_cnt_q <= sync_cnt_d;
      col_idx_q  <= col_idx_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      sh2_q      <= sh2_d;
      locked_q   <= locked_d;
      fv_q       <= fv_d;
      custom_q   <= custom_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign o_rx_dv       = rx_dv_q;
  assign o_rx_byte     = rx_byte_q;
  assign o_frame_err   = frame_err_q;
  assign o_locked      = locked_q;
  assign o_frame_valid = fv_q;
  assign o_custom_cmd  = custom_q;
  assign o_cmd         = cmd_q;
  assign o_data        = data_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 16 clocks per bit.
module tb_uart_rx_frame;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b1;
  logic        o_rx_dv, o_frame_err, o_locked, o_frame_valid;
  logic [7:0]  o_rx_byte, o_custom_cmd, o_cmd;
  logic [15:0] o_data;

  int total = 0;
  int bad = 0;

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .SYNC_BYTES(2), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx),
    .o_rx_dv(o_rx_dv), .o_rx_byte(o_rx_byte), .o_frame_err(o_frame_err),
    .o_locked(o_locked), .o_frame_valid(o_frame_valid),
    .o_custom_cmd(o_custom_cmd), .o_cmd(o_cmd), .o_data(o_data)
  );

  always #5 clk = ~clk;

  // Strobe monitor: counts pulses and captures frame fields on each valid.
  int cyc = 0, n_dv = 0, n_fv = 0, n_err = 0, dv_cyc = 0, fv_cyc = 0;
  logic [31:0] fv_rec[$];
  always @(negedge clk) begin
    cyc++;
    if (o_rx_dv) begin n_dv++; dv_cyc = cyc; end
    if (o_frame_err) n_err++;
    if (o_frame_valid) begin
      n_fv++; fv_cyc = cyc;
      fv_rec.push_back({o_custom_cmd, o_cmd, o_data});
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    settle(3);
    total++;
    if ({o_rx_dv, o_rx_byte, o_frame_err, o_locked, o_frame_valid} !== 12'h000) begin
      bad++; $display("FAIL reset_byte_side: got %h want 000",
                      {o_rx_dv, o_rx_byte, o_frame_err, o_locked, o_frame_valid});
    end
    total++;
    if ({o_custom_cmd, o_cmd, o_data} !== 32'h0) begin
      bad++; $display("FAIL reset_fields: got %h want 00000000", {o_custom_cmd, o_cmd, o_data});
    end
    reset_n = 1'b1;
    settle(4);
  endtask

  task automatic test_glitch;
    int dv0, e0;
    dv0 = n_dv; e0 = n_err;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    settle(30);
    total++;
    if (n_dv - dv0 !== 0 || n_err - e0 !== 0) begin
      bad++; $display("FAIL glitch_no_strobe: dv=%0d err=%0d want 0 0", n_dv - dv0, n_err - e0);
    end
    send_byte(8'hA3, 1'b1);
    settle(4);
    total++;
    if (n_dv - dv0 !== 1) begin
      bad++; $display("FAIL glitch_then_byte_dv: got %0d want 1", n_dv - dv0);
    end
    total++;
    if (o_rx_byte !== 8'hA3) begin
      bad++; $display("FAIL glitch_then_byte_val: got %h want a3", o_rx_byte);
    end
  endtask

  task automatic test_lock_frame;
    int f0;
    send_byte(8'hFF, 1'b1);
    settle(4);
    total++;
    if (o_locked !== 1'b0) begin
      bad++; $display("FAIL lock_after_one_ff: got %b want 0", o_locked);
    end
    send_byte(8'hFF, 1'b1);
    settle(4);
    total++;
    if (o_locked !== 1'b1) begin
      bad++; $display("FAIL lock_after_two_ff: got %b want 1", o_locked);
    end
    f0 = n_fv;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    settle(4);
    total++;
    if (n_fv - f0 !== 1) begin
      bad++; $display("FAIL frame_valid_count: got %0d want 1", n_fv - f0);
    end
    total++;
    if (fv_cyc - dv_cyc !== 1) begin
      bad++; $display("FAIL frame_latency: got %0d want 1", fv_cyc - dv_cyc);
    end
    total++;
    if ({o_custom_cmd, o_cmd, o_data} !== 32'h1234ABCD) begin
      bad++; $display("FAIL frame_fields: got %h want 1234abcd", {o_custom_cmd, o_cmd, o_data});
    end
  endtask

  task automatic test_reset_mid;
    int dv0;
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB * 4 + 8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if ({o_rx_dv, o_rx_byte, o_frame_err, o_locked, o_frame_valid,
         o_custom_cmd, o_cmd, o_data} !== 44'h0) begin
      bad++; $display("FAIL reset_mid_outputs: got %h want 0",
                      {o_rx_dv, o_rx_byte, o_frame_err, o_locked, o_frame_valid,
                       o_custom_cmd, o_cmd, o_data});
    end
    repeat (5) @(negedge clk);
    rx = 1'b1;
    reset_n = 1'b1;
    settle(40);
    dv0 = n_dv;
    send_byte(8'h55, 1'b1);
    settle(4);
    total++;
    if (n_dv - dv0 !== 1 || o_rx_byte !== 8'h55) begin
      bad++; $display("FAIL reset_mid_rx: dv=%0d byte=%h want 1 55", n_dv - dv0, o_rx_byte);
    end
    total++;
    if (o_locked !== 1'b0) begin
      bad++; $display("FAIL reset_mid_unlocked: got %b want 0", o_locked);
    end
  endtask

  task automatic test_filler_b2b;
    int f0;
    f0 = n_fv;
    for (int i = 0; i < 13; i++) send_byte(8'hFF, 1'b1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    settle(4);
    total++;
    if (n_fv - f0 !== 2) begin
      bad++; $display("FAIL b2b_frame_count: got %0d want 2", n_fv - f0);
    end else begin
      total++;
      if (fv_rec[f0] !== 32'h01020304) begin
        bad++; $display("FAIL b2b_frame0: got %h want 01020304", fv_rec[f0]);
      end
      total++;
      if (fv_rec[f0 + 1] !== 32'h05060708) begin
        bad++; $display("FAIL b2b_frame1: got %h want 05060708", fv_rec[f0 + 1]);
      end
    end
    total++;
    if (o_locked !== 1'b1) begin
      bad++; $display("FAIL b2b_locked: got %b want 1", o_locked);
    end
  endtask

  task automatic test_frame_err;
    int dv0, e0, f0;
    dv0 = n_dv; e0 = n_err; f0 = n_fv;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h77, 1'b0);
    settle(40);
    total++;
    if (n_err - e0 !== 1 || n_dv - dv0 !== 2) begin
      bad++; $display("FAIL ferr_strobes: err=%0d dv=%0d want 1 2", n_err - e0, n_dv - dv0);
    end
    total++;
    if (o_locked !== 1'b0) begin
      bad++; $display("FAIL ferr_unlock: got %b want 0", o_locked);
    end
    total++;
    if (n_fv !== f0 || {o_custom_cmd, o_cmd, o_data} !== 32'h05060708) begin
      bad++; $display("FAIL ferr_hold: fv=%0d fields=%h want 0 05060708",
                      n_fv - f0, {o_custom_cmd, o_cmd, o_data});
    end
    total++;
    if (o_rx_byte !== 8'h02) begin
      bad++; $display("FAIL ferr_byte_hold: got %h want 02", o_rx_byte);
    end
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h09, 1'b1);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h0B, 1'b1);
    send_byte(8'h0C, 1'b1);
    settle(4);
    total++;
    if (o_locked !== 1'b1 || {o_custom_cmd, o_cmd, o_data} !== 32'h090A0B0C) begin
      bad++; $display("FAIL relock_frame: lock=%b fields=%h want 1 090a0b0c",
                      o_locked, {o_custom_cmd, o_cmd, o_data});
    end
  endtask

  task automatic test_timeout;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (400) @(negedge clk);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    settle(4);
    total++;
`ifdef UART_RX_TIMEOUT_EN
    if ({o_custom_cmd, o_cmd, o_data} !== 32'h11223344) begin
      bad++; $display("FAIL timeout_frame: got %h want 11223344", {o_custom_cmd, o_cmd, o_data});
    end
`else
    if ({o_custom_cmd, o_cmd, o_data} !== 32'h01021122) begin
      bad++; $display("FAIL no_timeout_frame: got %h want 01021122", {o_custom_cmd, o_cmd, o_data});
    end
`endif
    total++;
    if (o_locked !== 1'b1) begin
      bad++; $display("FAIL timeout_locked: got %b want 1", o_locked);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_lock_frame();
    test_reset_mid();
    test_filler_b2b();
    test_frame_err();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
